lns_fma_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one pipelined LNS fused multiply-add datapath among NREQ requesters. It accepts at most one operand triple per cycle and issues it to the datapath. A tag pipeline tracks each in-flight operation, so every result is routed back to the requester that issued it. The block sits between the requester front-ends and the synthesized LNS fmadd core, which is built from the standard-cell netlist.

---
 rtl/lns_fma_arbiter.sv | 114 +++++++++++
 tb/tb_lns_fma_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/lns_fma_arbiter.sv
// Round-robin arbiter sharing one pipelined LNS fmadd datapath among NREQ requesters.
// Latency LAT+2 cycles request-to-response; one outstanding op per requester, no response backpressure.
module lns_fma_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int LAT  = 3,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*W-1:0] req_c,
  output logic              fma_valid,
  output logic [W-1:0]      fma_a,
  output logic [W-1:0]      fma_b,
  output logic [W-1:0]      fma_c,
  input  logic [W-1:0]      fma_result,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              busy
);

  function automatic logic [IDW-1:0] add_mod(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [NREQ-1:0]         pending_q, pending_d;
  logic                    fma_vld_q, fma_vld_d;
  logic [W-1:0]            fma_a_q, fma_a_d, fma_b_q, fma_b_d, fma_c_q, fma_c_d;
  logic [LAT:0]            tag_vld_q, tag_vld_d;
  logic [LAT:0][IDW-1:0]   tag_id_q, tag_id_d;
  logic [NREQ-1:0]         rsp_vld_q, rsp_vld_d;
  logic [W-1:0]            rsp_dat_q, rsp_dat_d;

  logic [NREQ-1:0]         elig;
  logic [NREQ-1:0]         grant_oh;
  logic [IDW-1:0]          grant_id;
  logic [IDW-1:0]          cand;
  logic                    grant_vld;

  // A requester whose response is visible this cycle may re-issue immediately.
  always_comb begin
    elig      = req_valid & (~pending_q | rsp_vld_q);
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = add_mod(ptr_q, k);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
    if (rst) grant_vld = 1'b0;
    grant_oh = grant_vld ? (NREQ'(1) << grant_id) : '0;
  end

  always_comb begin
    ptr_d     = grant_vld ? add_mod(grant_id, 1) : ptr_q;
    pending_d = (pending_q & ~rsp_vld_q) | grant_oh;
    fma_vld_d = grant_vld;
    fma_a_d   = grant_vld ? req_a[grant_id*W +: W] : fma_a_q;
    fma_b_d   = grant_vld ? req_b[grant_id*W +: W] : fma_b_q;
    fma_c_d   = grant_vld ? req_c[grant_id*W +: W] : fma_c_q;
    // Stage 0 lines up with fma_valid; stage LAT lines up with fma_result.
    tag_vld_d = {tag_vld_q[LAT-1:0], grant_vld};
    tag_id_d  = {tag_id_q[LAT-1:0], grant_id};
    rsp_vld_d = tag_vld_q[LAT] ? (NREQ'(1) << tag_id_q[LAT]) : '0;
    rsp_dat_d = tag_vld_q[LAT] ? fma_result : rsp_dat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      pending_q <= '0;
      fma_vld_q <= 1'b0;
      fma_a_q   <= '0;
      fma_b_q   <= '0;
      fma_c_q   <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      rsp_vld_q <= '0;
      rsp_dat_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      fma_vld_q <= fma_vld_d;
      fma_a_q   <= fma_a_d;
      fma_b_q   <= fma_b_d;
      fma_c_q   <= fma_c_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

  assign req_ready = grant_oh;
  assign fma_valid = fma_vld_q;
  assign fma_a     = fma_a_q;
  assign fma_b     = fma_b_q;
  assign fma_c     = fma_c_q;
  assign rsp_valid = rsp_vld_q;
  assign rsp_data  = rsp_dat_q;
  assign busy      = |pending_q;

endmodule

// File: tb/tb_lns_fma_arbiter.sv
// Bench for lns_fma_arbiter: directed phases plus random traffic against a cycle-level reference model.
module tb_lns_fma_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int LAT  = 3;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid;
  logic [NREQ*W-1:0] req_a, req_b, req_c;
  logic              fma_valid, busy;
  logic [W-1:0]      fma_a, fma_b, fma_c, fma_result, rsp_data;
  logic [W-1:0]      dp [LAT];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model state
  int          due [NREQ];
  logic [W-1:0] res [NREQ];
  int          ptr;
  logic        exp_fv;
  logic [W-1:0] ea, eb, ec;
  logic        post_rst;

  always #5 clk = ~clk;

  lns_fma_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .fma_valid(fma_valid), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_result(fma_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  function automatic logic [W-1:0] dp_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
    return (a ^ {b[W-2:0], 1'b0}) + c;
  endfunction

  // stand-in for the LNS fmadd core: fixed LAT-cycle pipeline
  always @(posedge clk) begin
    dp[0] <= dp_fn(fma_a, fma_b, fma_c);
    for (int k = 1; k < LAT; k++) dp[k] <= dp[k-1];
  end
  assign fma_result = dp[LAT-1];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic run_cycle(input logic r, input logic [NREQ-1:0] v);
    logic [NREQ-1:0] exp_rdy, exp_rsp;
    logic [W-1:0]    exp_rd;
    logic            exp_busy;
    int              g;
    rst       = r;
    req_valid = v;
    req_a     = {$urandom(), $urandom()};
    req_b     = {$urandom(), $urandom()};
    req_c     = {$urandom(), $urandom()};
    @(negedge clk);
    exp_rsp  = '0;
    exp_rd   = '0;
    exp_busy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (due[i] == cyc) begin
        exp_rsp[i] = 1'b1;
        exp_rd     = res[i];
      end
      if (due[i] >= cyc) exp_busy = 1'b1;
    end
    g = -1;
    if (!r) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (ptr + k) % NREQ;
        if (g < 0 && v[i] && due[i] <= cyc) g = i;
      end
    end
    exp_rdy = (g >= 0) ? NREQ'(1) << g : '0;

    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("fma_valid", fma_valid, exp_fv);
    check_eq("fma_a", fma_a, ea);
    check_eq("fma_b", fma_b, eb);
    check_eq("fma_c", fma_c, ec);
    check_eq("rsp_valid", rsp_valid, exp_rsp);
    if (exp_rsp != '0) check_eq("rsp_data", rsp_data, exp_rd);
    if (post_rst) check_eq("rsp_data_rst", rsp_data, '0);
    check_eq("busy", busy, exp_busy);

    if (r) begin
      for (int i = 0; i < NREQ; i++) due[i] = -1;
      ptr    = 0;
      exp_fv = 1'b0;
      ea = '0; eb = '0; ec = '0;
    end else begin
      exp_fv = (g >= 0);
      if (g >= 0) begin
        ea      = req_a[g*W +: W];
        eb      = req_b[g*W +: W];
        ec      = req_c[g*W +: W];
        due[g]  = cyc + LAT + 2;
        res[g]  = dp_fn(ea, eb, ec);
        ptr     = (g + 1) % NREQ;
      end
    end
    post_rst = r;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      due[i] = -1;
      res[i] = '0;
    end
    ptr = 0; exp_fv = 1'b0; ea = '0; eb = '0; ec = '0; post_rst = 1'b1;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_c = '0;
    @(posedge clk);
    #1;
    // single request from requester 2 at cycle 10
    for (int n = 0; n < 10; n++) run_cycle(1'b0, 4'b0000);
    run_cycle(1'b0, 4'b0100);
    for (int n = 0; n < 8; n++) run_cycle(1'b0, 4'b0000);
    // everyone at once, then one hog, then alternating pair
    for (int n = 0; n < 14; n++) run_cycle(1'b0, 4'b1111);
    for (int n = 0; n < 8; n++) run_cycle(1'b0, 4'b0000);
    for (int n = 0; n < 12; n++) run_cycle(1'b0, 4'b0001);
    for (int n = 0; n < 8; n++) run_cycle(1'b0, 4'b0000);
    for (int n = 0; n < 14; n++) run_cycle(1'b0, 4'b1010);
    for (int n = 0; n < 8; n++) run_cycle(1'b0, 4'b0000);
    // reset while three operations are in flight
    for (int n = 0; n < 3; n++) run_cycle(1'b0, 4'b1111);
    run_cycle(1'b1, 4'b1111);
    run_cycle(1'b0, 4'b0000);
    run_cycle(1'b0, 4'b0010);
    for (int n = 0; n < 8; n++) run_cycle(1'b0, 4'b0000);
    // random traffic with occasional reset
    for (int n = 0; n < 400; n++)
      run_cycle($urandom_range(0, 39) == 0, NREQ'($urandom_range(0, 15)));
    for (int n = 0; n < 20; n++) run_cycle(1'b0, 4'b0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
